// File: rtl/pipeline_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// Covers op issue, flush, the MTHI/MTLO write path and the HI/LO/status readback.
interface pipeline_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             abort;
  logic             hiwe;
  logic             lowe;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, abort, hiwe, lowe, wdata,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, abort, hiwe, lowe, wdata,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/pipeline_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with private HI/LO, abort and divide-by-zero flag.
// Signed ops are built only when MULDIV_SIGNED_EN is defined; otherwise every op is unsigned.
module pipeline_muldiv #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              reset,
  pipeline_muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;

  assign sgn_a = bus.op[0] & bus.srca[WIDTH-1];
  assign sgn_b = bus.op[0] & bus.srcb[WIDTH-1];
  assign mag_a = sgn_a ? -bus.srca : bus.srca;
  assign mag_b = sgn_b ? -bus.srcb : bus.srcb;
`else
  logic               unused_op0;

  assign unused_op0 = bus.op[0];
  assign sgn_a      = 1'b0;
  assign sgn_b      = 1'b0;
  assign mag_a      = bus.srca;
  assign mag_b      = bus.srcb;
`endif

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: shift in the next dividend bit, subtract when it fits, quotient bit into LSB.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, mcand_q};
  assign div_diff = rem_sh[WIDTH-1:0] - mcand_q;
  assign div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    res_hi = acc_q[2*WIDTH-1:WIDTH];
    res_lo = acc_q[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (!dz_q) begin
      if (is_div_q) begin
        if (neg_q)     res_lo = -acc_q[WIDTH-1:0];
        if (rem_neg_q) res_hi = -acc_q[2*WIDTH-1:WIDTH];
      end else if (neg_q) begin
        {res_hi, res_lo} = -acc_q;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.hiwe) hi_d = bus.wdata;
        if (bus.lowe) lo_d = bus.wdata;
        if (bus.start && !bus.abort) begin
          is_div_d = bus.op[1];
          cnt_d    = CNTW'(WIDTH);
`ifdef MULDIV_SIGNED_EN
          neg_d     = sgn_a ^ sgn_b;
          rem_neg_d = sgn_a;
`endif
          if (bus.op[1] && (bus.srcb == '0)) begin
            // Divide-by-zero result is preloaded so FIX just copies it out.
            acc_d   = {bus.srca, {WIDTH{1'b1}}};
            dz_d    = 1'b1;
            state_d = StFix;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            mcand_d = bus.op[1] ? mag_b : mag_a;
            dz_d    = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.abort) begin
          hi_d      = res_hi;
          lo_d      = res_lo;
          done_d    = 1'b1;
          divzero_d = dz_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.divzero = divzero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Directed bench for pipeline_muldiv at WIDTH=32; signed-op expectations follow MULDIV_SIGNED_EN.
// Inputs are driven and outputs sampled on the falling edge; cycle k follows rising edge k-1.
module tb_pipeline_muldiv;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  pipeline_muldiv_if #(.WIDTH(32)) bus_if ();

  pipeline_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op and follows it until one cycle past done (or a 40-cycle bound).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int busy_end,
                       output logic [31:0] h, output logic [31:0] l, output logic dz,
                       output logic done_nx, output logic dz_nx);
    int cyc;
    cyc      = 0;
    done_cyc = -1;
    busy_end = -1;
    h        = '0;
    l        = '0;
    dz       = 1'b0;
    done_nx  = 1'b0;
    dz_nx    = 1'b0;
    bus_if.op    = op;
    bus_if.srca  = a;
    bus_if.srcb  = b;
    bus_if.start = 1'b1;
    while (cyc < 40 && !(done_cyc >= 0 && cyc > done_cyc)) begin
      @(negedge clk);
      cyc++;
      bus_if.start = 1'b0;
      if (done_cyc >= 0) begin
        done_nx = bus_if.done;
        dz_nx   = bus_if.divzero;
      end else if (bus_if.done) begin
        done_cyc = cyc;
        h        = bus_if.hi;
        l        = bus_if.lo;
        dz       = bus_if.divzero;
      end
      if (busy_end < 0 && !bus_if.busy) busy_end = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done got %b want 0", bus_if.done); end
    n_cmp++; if (bus_if.divzero !== 1'b0) begin n_fail++;
      $display("FAIL reset_divzero got %b want 0", bus_if.divzero); end
    n_cmp++; if (bus_if.hi !== 32'h0) begin n_fail++;
      $display("FAIL reset_hi got %h want 0", bus_if.hi); end
    n_cmp++; if (bus_if.lo !== 32'h0) begin n_fail++;
      $display("FAIL reset_lo got %h want 0", bus_if.lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int dc, be;
    logic [31:0] h, l;
    logic dz, dn, dzn;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (dc !== 34) begin n_fail++;
      $display("FAIL multu_done_cycle got %0d want 34", dc); end
    n_cmp++; if (be !== 34) begin n_fail++;
      $display("FAIL multu_busy_end got %0d want 34", be); end
    n_cmp++; if (h !== 32'hFFFF_FFFE) begin n_fail++;
      $display("FAIL multu_hi got %h want fffffffe", h); end
    n_cmp++; if (l !== 32'h0000_0001) begin n_fail++;
      $display("FAIL multu_lo got %h want 00000001", l); end
    n_cmp++; if (dn !== 1'b0) begin n_fail++;
      $display("FAIL multu_done_pulse got %b want 0 in cycle 35", dn); end
  endtask

  task automatic test_signed_mul();
    int dc, be;
    logic [31:0] h, l, eh;
    logic dz, dn, dzn;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF;
`else
    eh = 32'h0000_0006;
`endif
    do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (h !== eh) begin n_fail++;
      $display("FAIL mult_hi got %h want %h", h, eh); end
    n_cmp++; if (l !== 32'hFFFF_FFEB) begin n_fail++;
      $display("FAIL mult_lo got %h want ffffffeb", l); end
  endtask

  task automatic test_signed_div();
    int dc, be;
    logic [31:0] h, l, eh, el;
    logic dz, dn, dzn;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD;
`else
    eh = 32'h0000_0001; el = 32'h7FFF_FFFC;
`endif
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (l !== el) begin n_fail++;
      $display("FAIL div_lo got %h want %h", l, el); end
    n_cmp++; if (h !== eh) begin n_fail++;
      $display("FAIL div_hi got %h want %h", h, eh); end
    n_cmp++; if (dc !== 34) begin n_fail++;
      $display("FAIL div_done_cycle got %0d want 34", dc); end
  endtask

  task automatic test_min_neg();
    int dc, be;
    logic [31:0] h, l, eh, el;
    logic dz, dn, dzn;
`ifdef MULDIV_SIGNED_EN
    eh = 32'h0000_0000; el = 32'h8000_0000;
`else
    eh = 32'h8000_0000; el = 32'h0000_0000;
`endif
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (l !== el) begin n_fail++;
      $display("FAIL minneg_lo got %h want %h", l, el); end
    n_cmp++; if (h !== eh) begin n_fail++;
      $display("FAIL minneg_hi got %h want %h", h, eh); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++;
      $display("FAIL minneg_divzero got %b want 0", dz); end
  endtask

  task automatic test_divzero();
    int dc, be;
    logic [31:0] h, l;
    logic dz, dn, dzn;
    do_op(2'b10, 32'h0000_0005, 32'h0000_0000, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (be !== 2) begin n_fail++;
      $display("FAIL divzero_busy_end got %0d want 2", be); end
    n_cmp++; if (dc !== 2) begin n_fail++;
      $display("FAIL divzero_done_cycle got %0d want 2", dc); end
    n_cmp++; if (dz !== 1'b1) begin n_fail++;
      $display("FAIL divzero_flag got %b want 1", dz); end
    n_cmp++; if (h !== 32'h0000_0005) begin n_fail++;
      $display("FAIL divzero_hi got %h want 00000005", h); end
    n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL divzero_lo got %h want ffffffff", l); end
    n_cmp++; if (dzn !== 1'b0) begin n_fail++;
      $display("FAIL divzero_flag_next got %b want 0", dzn); end
  endtask

  task automatic test_reset_midop();
    int dc, be;
    logic [31:0] h, l;
    logic dz, dn, dzn;
    bus_if.op    = 2'b10;
    bus_if.srca  = 32'd100;
    bus_if.srcb  = 32'd7;
    bus_if.start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++;
      $display("FAIL midreset_busy got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.hi !== 32'h0) begin n_fail++;
      $display("FAIL midreset_hi got %h want 0", bus_if.hi); end
    n_cmp++; if (bus_if.lo !== 32'h0) begin n_fail++;
      $display("FAIL midreset_lo got %h want 0", bus_if.lo); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(2'b00, 32'd6, 32'd7, dc, be, h, l, dz, dn, dzn);
    n_cmp++; if (dc !== 34) begin n_fail++;
      $display("FAIL postreset_done_cycle got %0d want 34", dc); end
    n_cmp++; if (l !== 32'd42) begin n_fail++;
      $display("FAIL postreset_lo got %0d want 42", l); end
    n_cmp++; if (h !== 32'd0) begin n_fail++;
      $display("FAIL postreset_hi got %h want 0", h); end
  endtask

  task automatic test_abort();
    logic saw_done;
    logic busy11;
    bus_if.hiwe  = 1'b1;
    bus_if.wdata = 32'h11;
    @(negedge clk);
    bus_if.hiwe  = 1'b0;
    bus_if.lowe  = 1'b1;
    bus_if.wdata = 32'h22;
    @(negedge clk);
    bus_if.lowe  = 1'b0;
    n_cmp++; if (bus_if.hi !== 32'h11) begin n_fail++;
      $display("FAIL mthi got %h want 11", bus_if.hi); end
    n_cmp++; if (bus_if.lo !== 32'h22) begin n_fail++;
      $display("FAIL mtlo got %h want 22", bus_if.lo); end
    saw_done = 1'b0;
    busy11   = 1'b1;
    bus_if.op    = 2'b00;
    bus_if.srca  = 32'd6;
    bus_if.srcb  = 32'd7;
    bus_if.start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus_if.done) saw_done = 1'b1;
      if (cyc == 11) busy11 = bus_if.busy;
      case (cyc)
        1:  bus_if.start = 1'b0;
        3:  begin bus_if.hiwe = 1'b1; bus_if.wdata = 32'h99; end
        4:  bus_if.hiwe = 1'b0;
        5:  begin bus_if.start = 1'b1; bus_if.op = 2'b10; bus_if.srca = 1; bus_if.srcb = 1; end
        6:  bus_if.start = 1'b0;
        10: bus_if.abort = 1'b1;
        11: bus_if.abort = 1'b0;
        default: ;
      endcase
    end
    n_cmp++; if (busy11 !== 1'b0) begin n_fail++;
      $display("FAIL abort_busy got %b want 0 in cycle 11", busy11); end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++;
      $display("FAIL abort_done got %b want 0", saw_done); end
    n_cmp++; if (bus_if.hi !== 32'h11) begin n_fail++;
      $display("FAIL abort_hi got %h want 11", bus_if.hi); end
    n_cmp++; if (bus_if.lo !== 32'h22) begin n_fail++;
      $display("FAIL abort_lo got %h want 22", bus_if.lo); end
  endtask

  task automatic test_abort_idle();
    bus_if.op    = 2'b00;
    bus_if.srca  = 32'd2;
    bus_if.srcb  = 32'd3;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++;
      $display("FAIL idle_abort_busy got %b want 0", bus_if.busy); end
  endtask

  task automatic test_write_with_start();
    int dc;
    logic [31:0] h, l;
    dc = -1;
    h  = '0;
    l  = '0;
    bus_if.hiwe  = 1'b1;
    bus_if.wdata = 32'h55;
    bus_if.op    = 2'b00;
    bus_if.srca  = 32'd2;
    bus_if.srcb  = 32'd3;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.hiwe  = 1'b0;
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.hi !== 32'h55) begin n_fail++;
      $display("FAIL wstart_hi got %h want 55", bus_if.hi); end
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_fail++;
      $display("FAIL wstart_busy got %b want 1", bus_if.busy); end
    for (int cyc = 2; cyc <= 40 && dc < 0; cyc++) begin
      @(negedge clk);
      if (bus_if.done) begin dc = cyc; h = bus_if.hi; l = bus_if.lo; end
    end
    n_cmp++; if (dc !== 34) begin n_fail++;
      $display("FAIL wstart_done_cycle got %0d want 34", dc); end
    n_cmp++; if (l !== 32'd6) begin n_fail++;
      $display("FAIL wstart_lo got %h want 6", l); end
    n_cmp++; if (h !== 32'd0) begin n_fail++;
      $display("FAIL wstart_hi_result got %h want 0", h); end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.srca  = '0;
    bus_if.srcb  = '0;
    bus_if.abort = 1'b0;
    bus_if.hiwe  = 1'b0;
    bus_if.lowe  = 1'b0;
    bus_if.wdata = '0;
    @(negedge clk);
    test_reset();
    test_multu();
    test_signed_mul();
    test_signed_div();
    test_min_neg();
    test_divzero();
    test_reset_midop();
    test_abort();
    test_abort_idle();
    test_write_with_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
